// File: rtl/pipe_run_ctrl.sv
// Run controller for the pipelined core: stretches the core reset, counts run cycles and
// retired instructions, then drains after halt and flags done, or flags timeout.
module pipe_run_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 4,
  parameter int RET_CH       = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RET_CH-1:0] retire_valid,
  input  logic              halt,
  output logic              dut_rst_n,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT
  } state_t;

  localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
  localparam int POP_W   = $clog2(RET_CH + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic                dut_rst_n_q, dut_rst_n_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;

  logic [POP_W-1:0]    pop;
  logic [CNT_W:0]      ret_sum;
  logic [CNT_W-1:0]    ret_sat;

  // Saturating accumulate of this cycle's retires; the carry bit flags overflow.
  always_comb begin
    pop = '0;
    for (int i = 0; i < RET_CH; i++) begin
      pop = pop + POP_W'(retire_valid[i]);
    end
    ret_sum = {1'b0, ret_q} + (CNT_W + 1)'(pop);
    ret_sat = ret_sum[CNT_W] ? {CNT_W{1'b1}} : ret_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    drain_d     = drain_q;
    cyc_d       = cyc_q;
    ret_d       = ret_q;
    dut_rst_n_d = dut_rst_n_q;
    running_d   = running_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d     = S_HOLD;
          hold_d      = HOLD_LOAD;
          cyc_d       = '0;
          ret_d       = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          dut_rst_n_d = 1'b0;
          running_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d     = S_RUN;
          dut_rst_n_d = 1'b1;
          running_d   = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        ret_d = ret_sat;
        // halt takes priority over budget expiry on the same edge
        if (halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cyc_q == CYC_LAST) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
          running_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end else begin
          ret_d   = ret_sat;
          drain_d = drain_q - 1'b1;
          if (drain_q == DRAIN_W'(1)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            running_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      drain_q     <= '0;
      cyc_q       <= '0;
      ret_q       <= '0;
      dut_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      drain_q     <= drain_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      dut_rst_n_q <= dut_rst_n_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign dut_rst_n    = dut_rst_n_q;
  assign running      = running_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule
